// File: rtl/ddr3_app_arbiter.sv
// Shares the MIG app interface between a write and a read requester with round-robin bursts.
// Zero-cycle accept inside a granted state; reads limited to RD_MAX in flight, returned in order.
module ddr3_app_arbiter #(
  parameter int ADDR_W    = 33,
  parameter int DATA_W    = 128,
  parameter int BURST_MAX = 16,
  parameter int RD_MAX    = 16
) (
  input  logic                ui_clk,
  input  logic                rst_n,
  input  logic                init_calib_complete,
  input  logic                w_valid,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_mask,
  output logic                w_ready,
  input  logic                r_valid,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic                r_ready,
  output logic [DATA_W-1:0]   r_data,
  output logic                r_data_valid,
  input  logic                app_rdy,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  input  logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int RW = $clog2(RD_MAX + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);
  localparam logic [RW-1:0] RD_LIM    = RW'(RD_MAX);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t        state_q, state_d;
  logic          last_rd_q, last_rd_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [RW-1:0] rd_cnt_q, rd_cnt_d;
  logic          burst_done, rd_full, w_acc, r_acc, rd_ret;

  always_comb begin
    burst_done = (burst_cnt_q == BURST_LIM);
    rd_full    = (rd_cnt_q == RD_LIM);
    w_ready    = 1'b0;
    r_ready    = 1'b0;
    // A side at its burst limit stops accepting once the other side is waiting,
    // which produces the single dead cycle of a switch.
    if (init_calib_complete) begin
      if (state_q == WRITE) w_ready = app_rdy & app_wdf_rdy & ~(burst_done & r_valid);
      if (state_q == READ)  r_ready = app_rdy & ~rd_full & ~(burst_done & w_valid);
    end
    w_acc = w_valid & w_ready;
    r_acc = r_valid & r_ready;

    app_en       = w_acc | r_acc;
    app_cmd      = (state_q == READ) ? 3'b001 : 3'b000;
    app_addr     = (state_q == READ) ? r_addr : w_addr;
    app_wdf_data = w_data;
    app_wdf_mask = w_mask;
    app_wdf_wren = w_acc;
    app_wdf_end  = w_acc;
    r_data       = app_rd_data;
    r_data_valid = app_rd_data_valid;

    state_d = state_q;
    if (!init_calib_complete) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (w_valid && (!r_valid || last_rd_q)) state_d = WRITE;
          else if (r_valid)                       state_d = READ;
        end
        WRITE: begin
          if (r_valid && (!w_valid || burst_done)) state_d = READ;
          else if (!w_valid && !r_valid)           state_d = IDLE;
        end
        READ: begin
          if (w_valid && (!r_valid || burst_done || rd_full)) state_d = WRITE;
          else if (!w_valid && !r_valid)                      state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    last_rd_d = last_rd_q;
    if (state_d != state_q && state_d != IDLE) last_rd_d = (state_d == READ);

    burst_cnt_d = burst_cnt_q;
    if (state_d != state_q)        burst_cnt_d = '0;
    else if (app_en && !burst_done) burst_cnt_d = burst_cnt_q + BW'(1);

    // Returns with nothing outstanding (e.g. stale data after reset) are not counted.
    rd_ret   = app_rd_data_valid & (rd_cnt_q != '0);
    rd_cnt_d = rd_cnt_q;
    unique case ({r_acc, rd_ret})
      2'b10:   rd_cnt_d = rd_cnt_q + RW'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - RW'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_rd_q   <= 1'b1;
      burst_cnt_q <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_rd_q   <= last_rd_d;
      burst_cnt_q <= burst_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

endmodule
